// File: rtl/result_seg_display.sv
// ALU result latch driving a 4-digit multiplexed common-anode 7-segment display.
// Optional macro NEG_BLINK_EN blanks the display at a slow rate while flag_ng is set.
module result_seg_display #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        hold,
  input  logic [15:0] data,
  input  logic        zr,
  input  logic        ng,
  output logic [15:0] shown,
  output logic        flag_zr,
  output logic        flag_ng,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shown_q, shown_d;
  logic          zr_q, zr_d;
  logic          ng_q, ng_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          cap;
  logic          blank;

  assign cap = load & ~hold;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      default: f = 7'b0001110;
    endcase
    return f;
  endfunction

  always_comb begin
    tick_d  = tick_q + TW'(1);
    idx_d   = idx_q;
    shown_d = shown_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    if (tick_q == TICK_MAX) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    if (cap) begin
      shown_d = data;
      zr_d    = zr;
      ng_d    = ng;
    end
    // Outputs lag the scan index by one cycle.
    an_d  = ~(4'b0001 << idx_q);
    seg_d = font(shown_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

`ifdef NEG_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (cap) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BLINK_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank = ng_q & phase_q;
`else
  assign blank = 1'b0 & (BLINK_TICKS > 0);
`endif

  assign shown   = shown_q;
  assign flag_zr = zr_q;
  assign flag_ng = ng_q;
  assign an      = an_q | {4{blank}};
  assign seg     = seg_q;

endmodule

// File: tb/tb_result_seg_display.sv
// Randomized bench for result_seg_display against a cycle-count reference model.
// Directed scenarios cover reset, scan order, hold, async reset and blinking.
module tb_result_seg_display;

  localparam int DT = 4;
  localparam int BT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] data = '0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] shown;
  logic        flag_zr;
  logic        flag_ng;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_tot = 0;
  int n_bad = 0;

  result_seg_display #(
    .DIGIT_TICKS(DT),
    .BLINK_TICKS(BT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .hold(hold),
    .data(data),
    .zr(zr),
    .ng(ng),
    .shown(shown),
    .flag_zr(flag_zr),
    .flag_ng(flag_ng),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] font_t [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: edges since reset release, edges since last capture.
  int          edges;
  int          bm;
  logic [15:0] m_shown;
  logic        m_zr;
  logic        m_ng;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;

  function automatic int dig_of(input int e);
    return (e / DT) % 4;
  endfunction

  function automatic logic [3:0] an_of(input int e);
    return ~(4'b0001 << dig_of(e));
  endfunction

  function automatic logic [6:0] seg_of(input logic [15:0] s, input int e);
    logic [15:0] t;
    t = s >> (4 * dig_of(e));
    return font_t[t[3:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges   <= 0;
      bm      <= 0;
      m_shown <= '0;
      m_zr    <= 1'b0;
      m_ng    <= 1'b0;
      e_an    <= 4'b1111;
      e_seg   <= 7'b1111111;
    end else begin
      e_an  <= an_of(edges);
      e_seg <= seg_of(m_shown, edges);
      edges <= edges + 1;
      if (load && !hold) begin
        m_shown <= data;
        m_zr    <= zr;
        m_ng    <= ng;
        bm      <= 0;
      end else begin
        bm <= bm + 1;
      end
    end
  end

  function automatic logic model_blank();
`ifdef NEG_BLINK_EN
    return m_ng && (((bm / BT) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an", 32'(an), 32'(e_an | {4{model_blank()}}));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("shown", 32'(shown), 32'(m_shown));
    chk("zr", 32'(flag_zr), 32'(m_zr));
    chk("ng", 32'(flag_ng), 32'(m_ng));
  endtask

  task automatic cyc(input logic ld, input logic hd, input logic [15:0] d,
                     input logic z, input logic n);
    load = ld;
    hold = hd;
    data = d;
    zr   = z;
    ng   = n;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    hold = 1'b0;
    check_all();
  endtask

  initial begin
    bit found;
    logic exp_blank;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_an", 32'(an), 32'h0000_000f);
    chk("rst_seg", 32'(seg), 32'h0000_007f);
    chk("rst_shown", 32'(shown), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release also captures A5F0.
    cyc(1'b1, 1'b0, 16'hA5F0, 1'b0, 1'b0);
    chk("first_an", 32'(an), 32'h0000_000e);
    chk("first_seg", 32'(seg), 32'b1000000);
    chk("first_shown", 32'(shown), 32'h0000_a5f0);
    for (int k = 2; k <= 17; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (k == 5) begin
        chk("scan1_an", 32'(an), 32'b1101);
        chk("scan1_seg", 32'(seg), 32'b0001110);
      end
      if (k == 9) begin
        chk("scan2_an", 32'(an), 32'b1011);
        chk("scan2_seg", 32'(seg), 32'b0010010);
      end
      if (k == 13) begin
        chk("scan3_an", 32'(an), 32'b0111);
        chk("scan3_seg", 32'(seg), 32'b0001000);
      end
      if (k == 17) chk("wrap_an", 32'(an), 32'b1110);
    end

    cyc(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    chk("hold_shown", 32'(shown), 32'h0000_a5f0);
    cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
    chk("cap_shown", 32'(shown), 32'h0000_1234);
    chk("cap_zr", 32'(flag_zr), 32'h1);
    chk("cap_ng", 32'(flag_ng), 32'h0);

    // Async reset while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (an == 4'b1011) found = 1'b1;
      else cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    end
    chk("find_1011", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'h0000_000f);
    chk("async_seg", 32'(seg), 32'h0000_007f);
    chk("async_shown", 32'(shown), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("restart_an", 32'(an), 32'b1110);

    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("zero_zr", 32'(flag_zr), 32'h1);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("zero_seg", 32'(seg), 32'b1000000);
    end

    cyc(1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    chk("blink_j0", 32'(an == 4'b1111), 32'h0);
    for (int j = 1; j < 24; j++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
`ifdef NEG_BLINK_EN
      exp_blank = (j >= 8) && (j <= 15);
`else
      exp_blank = 1'b0;
`endif
      chk("blink_ng1", 32'(an == 4'b1111), 32'(exp_blank));
    end
    cyc(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0);
    for (int j = 1; j < 24; j++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("blink_ng0", 32'(an == 4'b1111), 32'h0);
    end

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) == 0, ($urandom % 4) == 0,
          16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
